// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package disp_pkg;

    localparam int N_DIGITS_DEF = 8;
    localparam logic [N_DIGITS_DEF-1:0] ANODES_OFF = '1;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Display-side bus of the scan driver: value/load/enables in, scan outputs back.
interface seven_seg_scan_driver_if
    import disp_pkg::*;
#(
    parameter int N_DIGITS = N_DIGITS_DEF
) ();

    localparam int IDX_W = cnt_width(N_DIGITS);

    logic [4*N_DIGITS-1:0] value;
    logic                  load;
    logic [N_DIGITS-1:0]   digit_en;
    logic [3:0]            bcd_out;
    logic [N_DIGITS-1:0]   anodes;
    logic [IDX_W-1:0]      digit_idx;
    logic                  frame_done;

    modport master (
        output value, load, digit_en,
        input  bcd_out, anodes, digit_idx, frame_done
    );

    modport slave (
        input  value, load, digit_en,
        output bcd_out, anodes, digit_idx, frame_done
    );

endinterface

// File: rtl/seven_seg_scan_driver_slot_timer.sv
// Free-running prescaler: counts 0..DIV-1 and flags the terminal count.
module slot_timer
    import disp_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int CNT_W = cnt_width(DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] slot_cnt_o,
    output logic             slot_tick_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count with wrap at the terminal value.
    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign slot_cnt_o  = cnt_q;
    assign slot_tick_o = (cnt_q == LAST);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Eight-digit seven-segment scanner with dead-time blanking and frame-aligned
// double buffering of the displayed value.
module seven_seg_scan_driver
    import disp_pkg::*;
#(
    parameter int N_DIGITS     = N_DIGITS_DEF,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seven_seg_scan_driver_if.slave disp
);

    localparam int IDX_W = cnt_width(N_DIGITS);
    localparam int CNT_W = cnt_width(REFRESH_DIV);
    localparam int VAL_W = 4 * N_DIGITS;

    localparam logic [IDX_W-1:0]    LAST_DIGIT = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [N_DIGITS-1:0] ALL_OFF    = '1;

    logic [CNT_W-1:0]    slot_cnt_s;
    logic                slot_tick_s;
    logic                wrap_s;

    scan_state_t         state_q,      state_d;
    logic [IDX_W-1:0]    idx_q,        idx_d;
    logic [VAL_W-1:0]    pending_q,    pending_d;
    logic [VAL_W-1:0]    shadow_q,     shadow_d;
    logic [3:0]          bcd_q,        bcd_d;
    logic [N_DIGITS-1:0] anodes_q,     anodes_d;
    logic                frame_done_q, frame_done_d;

    slot_timer #(
        .DIV   (REFRESH_DIV),
        .CNT_W (CNT_W)
    ) u_slot_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .slot_cnt_o  (slot_cnt_s),
        .slot_tick_o (slot_tick_s)
    );

    // Next-state for digit counter, blanking FSM, buffers and outputs.
    always_comb begin
        wrap_s = slot_tick_s && (idx_q == LAST_DIGIT);

        if (slot_tick_s) begin
            if (idx_q == LAST_DIGIT) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end

        if (BLANK_CYCLES == 0) begin
            state_d = ON;
        end else if (slot_tick_s) begin
            state_d = BLANK;
        end else if ((state_q == BLANK) && (slot_cnt_s == BLANK_LAST)) begin
            state_d = ON;
        end else begin
            state_d = state_q;
        end

        // A load landing on the wrap bypasses pending so it shows in this frame.
        pending_d = disp.load ? disp.value : pending_q;
        if (wrap_s) begin
            shadow_d = disp.load ? disp.value : pending_q;
        end else begin
            shadow_d = shadow_q;
        end

        bcd_d = shadow_d[{idx_d, 2'b00} +: 4];

        anodes_d = ALL_OFF;
        if (state_d == ON) begin
            anodes_d[idx_d] = ~disp.digit_en[idx_d];
        end else begin
            anodes_d = ALL_OFF;
        end

        frame_done_d = wrap_s;
    end

    // Scan FSM, buffers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BLANK;
            idx_q        <= {IDX_W{1'b0}};
            pending_q    <= {VAL_W{1'b0}};
            shadow_q     <= {VAL_W{1'b0}};
            bcd_q        <= 4'h0;
            anodes_q     <= ALL_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            bcd_q        <= bcd_d;
            anodes_q     <= anodes_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign disp.bcd_out    = bcd_q;
    assign disp.anodes     = anodes_q;
    assign disp.digit_idx  = idx_q;
    assign disp.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench: cycle-count reference model feeding a scoreboard queue,
// a full-scan vector table and hand sequences for buffering and reset corners.
module tb_seven_seg_scan_driver;
    import disp_pkg::*;

    localparam int ND  = 8;
    localparam int DIV = 4;
    localparam int BLK = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seven_seg_scan_driver_if #(.N_DIGITS(ND)) ifc ();

    seven_seg_scan_driver #(
        .N_DIGITS     (ND),
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .disp  (ifc)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [3:0] bcd;
        logic [7:0] an;
        logic [2:0] idx;
        logic       fd;
    } exp_t;

    typedef struct {
        logic [31:0] value;
        logic [7:0]  en;
        logic [3:0]  bcd;
        logic [7:0]  an;
    } scan_vec_t;

    exp_t        exp_q[$];
    exp_t        e_m;
    exp_t        e_c;
    scan_vec_t   tbl[8];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          k_m    = 0;
    int          cnt_m;
    int          dig_m;
    logic [31:0] pend_m = '0;
    logic [31:0] shad_m = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (k=%0d)", name, act, req, k_m);
        end
    endtask

    task automatic wait_k(input int target);
        for (int i = 0; i < 400 && k_m != target; i++) @(negedge clk);
        if (k_m != target) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_k: got k=%0d, expected %0d", k_m, target);
        end
    endtask

    // Reference model: derives slot, digit and anode pattern from edges since reset.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                k_m    = 0;
                pend_m = '0;
                shad_m = '0;
                exp_q.delete();
            end else begin
                k_m   = k_m + 1;
                cnt_m = k_m % DIV;
                dig_m = (k_m / DIV) % ND;
                if (cnt_m == 0 && dig_m == 0) shad_m = ifc.load ? ifc.value : pend_m;
                if (ifc.load) pend_m = ifc.value;
                e_m.bcd = shad_m[dig_m*4 +: 4];
                e_m.idx = 3'(dig_m);
                e_m.fd  = (cnt_m == 0 && dig_m == 0);
                e_m.an  = 8'hFF;
                if (cnt_m >= BLK && ifc.digit_en[dig_m]) e_m.an[dig_m] = 1'b0;
                exp_q.push_back(e_m);
            end
        end
    end

    // Scoreboard: compare each cycle's DUT outputs away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                e_c = exp_q.pop_front();
                chk("sb_bcd_out",    {28'h0, ifc.bcd_out},     {28'h0, e_c.bcd});
                chk("sb_anodes",     {24'h0, ifc.anodes},      {24'h0, e_c.an});
                chk("sb_digit_idx",  {29'h0, ifc.digit_idx},   {29'h0, e_c.idx});
                chk("sb_frame_done", {31'h0, ifc.frame_done},  {31'h0, e_c.fd});
            end
        end
    end

    initial begin
        tbl[0] = '{32'h89ABCDEF, 8'hFF, 4'hF, 8'hFE};
        tbl[1] = '{32'h89ABCDEF, 8'hFF, 4'hE, 8'hFD};
        tbl[2] = '{32'h89ABCDEF, 8'hFF, 4'hD, 8'hFB};
        tbl[3] = '{32'h89ABCDEF, 8'hFF, 4'hC, 8'hF7};
        tbl[4] = '{32'h89ABCDEF, 8'hFF, 4'hB, 8'hEF};
        tbl[5] = '{32'h89ABCDEF, 8'hFF, 4'hA, 8'hDF};
        tbl[6] = '{32'h89ABCDEF, 8'hFF, 4'h9, 8'hBF};
        tbl[7] = '{32'h89ABCDEF, 8'hFF, 4'h8, 8'h7F};

        ifc.value    = 32'h0;
        ifc.load     = 1'b0;
        ifc.digit_en = 8'hFF;

        // Reset values while held.
        repeat (3) @(negedge clk);
        chk("rst_anodes",     {24'h0, ifc.anodes},     {24'h0, ANODES_OFF});
        chk("rst_bcd_out",    {28'h0, ifc.bcd_out},    32'h0);
        chk("rst_digit_idx",  {29'h0, ifc.digit_idx},  32'h0);
        chk("rst_frame_done", {31'h0, ifc.frame_done}, 32'h0);

        // Release with a load of the full-scan value in the first cycle.
        ifc.value = tbl[0].value;
        ifc.load  = 1'b1;
        rst_n     = 1'b1;
        #1;
        chk("slot0_blank", {24'h0, ifc.anodes}, 32'hFF);
        @(negedge clk);
        ifc.load = 1'b0;
        chk("slot0_on", {24'h0, ifc.anodes}, 32'hFE);

        wait_k(32);
        chk("first_wrap_fd", {31'h0, ifc.frame_done}, 32'h1);

        // Second frame: table of expected nibbles and anodes per digit.
        for (int d = 0; d < 8; d++) begin
            ifc.digit_en = tbl[d].en;
            wait_k(32 + 4*d + 2);
            chk("scan_bcd_out",   {28'h0, ifc.bcd_out},   {28'h0, tbl[d].bcd});
            chk("scan_anodes",    {24'h0, ifc.anodes},    {24'h0, tbl[d].an});
            chk("scan_digit_idx", {29'h0, ifc.digit_idx}, d);
        end

        // Get 2s on screen, then load 1s mid-frame.
        wait_k(66);
        ifc.value = 32'h22222222;
        ifc.load  = 1'b1;
        @(negedge clk);
        ifc.load = 1'b0;
        wait_k(110);
        ifc.value = 32'h11111111;
        ifc.load  = 1'b1;
        @(negedge clk);
        ifc.load = 1'b0;
        wait_k(122);
        chk("dbuf_old_frame", {28'h0, ifc.bcd_out}, 32'h2);
        wait_k(130);
        chk("dbuf_new_frame", {28'h0, ifc.bcd_out}, 32'h1);

        // Load in the slot_tick cycle of digit 7.
        wait_k(158);
        chk("wrap_pre_digit7", {28'h0, ifc.bcd_out}, 32'h1);
        @(negedge clk);
        ifc.value = 32'h3C3C3C3C;
        ifc.load  = 1'b1;
        @(negedge clk);
        ifc.load = 1'b0;
        chk("wrap_load_bcd", {28'h0, ifc.bcd_out}, 32'hC);
        chk("wrap_load_fd",  {31'h0, ifc.frame_done}, 32'h1);

        // Mask the upper four digits for a frame.
        ifc.digit_en = 8'h0F;
        wait_k(194);
        chk("mask_digit0_on", {24'h0, ifc.anodes}, 32'hFE);
        wait_k(214);
        chk("mask_digit5_off", {24'h0, ifc.anodes},  32'hFF);
        chk("mask_digit5_bcd", {28'h0, ifc.bcd_out}, 32'h3);
        ifc.digit_en = 8'hFF;

        // Asynchronous reset during digit 5 ON.
        wait_k(246);
        chk("pre_reset_anodes", {24'h0, ifc.anodes}, 32'hDF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_anodes",     {24'h0, ifc.anodes},     32'hFF);
        chk("async_bcd_out",    {28'h0, ifc.bcd_out},    32'h0);
        chk("async_digit_idx",  {29'h0, ifc.digit_idx},  32'h0);
        chk("async_frame_done", {31'h0, ifc.frame_done}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_k(2);
        chk("restart_anodes", {24'h0, ifc.anodes},  32'hFE);
        chk("restart_bcd",    {28'h0, ifc.bcd_out}, 32'h0);
        wait_k(42);
        chk("restart_shadow", {28'h0, ifc.bcd_out},   32'h0);
        chk("restart_idx",    {29'h0, ifc.digit_idx}, 32'h2);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
